// File: rtl/ctrl_vector_player_pkg.sv
// ctrl_vector_player_pkg
// Shared definitions for the control-vector player: FSM state encoding,
// default parameter values and the error-counter width.
package ctrl_vector_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int CW_WIDTH_DEF  = 42;
    localparam int RES_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int ERR_COUNT_W   = 8;

endpackage

// File: rtl/ctrl_vector_player_vector_ram.sv
// vector_ram
// Vector storage for the player: one write port and one synchronous read
// port. A read and a write to the same address on the same edge returns the
// old contents. The array itself is never reset; only the read register is.
// Ports:
//   Clock    rising-edge clock
//   Reset    asynchronous active-low reset (clears the read register only)
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data holds when low
//   rd_addr  read address
//   rd_data  registered read data
module vector_ram
    import ctrl_vector_player_pkg::*;
#(
    parameter int WIDTH = CW_WIDTH_DEF + RES_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ctrl_vector_player.sv
// ctrl_vector_player
// Plays a table of control words into a datapath, one per cycle (RUN) or one
// per step pulse (HOLD), optionally looping, and checks the datapath result
// one cycle after each word against the stored expected value.
// Optional feature macro: VECTOR_CHECK_EN (expected-result storage, compare,
// err_count and last_err_addr). When undefined the checker is absent and
// err_count / last_err_addr read as zero.
// Ports:
//   Clock, Reset         clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data vector-memory write port, data = {cw, expected}
//   len                  vectors per run (0 or >DEPTH means DEPTH)
//   start/stop           begin at entry 0 / abort (stop wins)
//   step_mode/step       single-step control
//   loop_en              wrap to entry 0 after the last entry
//   observed             datapath result for the previous control word
//   ctrl_word/ctrl_valid control word presented to the datapath
//   busy/done            FSM not idle / end-of-run pulse
//   err_count            saturating mismatch count
//   last_err_addr        entry index of the most recent mismatch
module ctrl_vector_player
    import ctrl_vector_player_pkg::*;
#(
    parameter int CW_WIDTH  = CW_WIDTH_DEF,
    parameter int RES_WIDTH = RES_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          wr_en,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr,
    input  logic [CW_WIDTH+RES_WIDTH-1:0] wr_data,
    input  logic [$clog2(DEPTH):0]        len,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          step_mode,
    input  logic                          step,
    input  logic                          loop_en,
    input  logic [RES_WIDTH-1:0]          observed,
    output logic [CW_WIDTH-1:0]           ctrl_word,
    output logic                          ctrl_valid,
    output logic                          busy,
    output logic                          done,
    output logic [ERR_COUNT_W-1:0]        err_count,
    output logic [$clog2(DEPTH)-1:0]      last_err_addr
);

    localparam int AW = $clog2(DEPTH);
`ifdef VECTOR_CHECK_EN
    localparam int MW = CW_WIDTH + RES_WIDTH;
`else
    localparam int MW = CW_WIDTH;
`endif
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          issue;
    logic          ctrl_valid_q;
    logic          done_q, done_d;
    logic          clr_err;
    logic [AW:0]   eff_len, len_m1;
    logic          at_last;
    logic [MW-1:0] ram_wdata, ram_rdata;

`ifdef VECTOR_CHECK_EN
    assign ram_wdata = wr_data;
`else
    assign ram_wdata = wr_data[CW_WIDTH+RES_WIDTH-1 -: CW_WIDTH];
`endif

    vector_ram #(
        .WIDTH (MW),
        .DEPTH (DEPTH)
    ) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (ram_wdata),
        .rd_en   (issue),
        .rd_addr (ptr_q),
        .rd_data (ram_rdata)
    );

    assign eff_len = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
    assign len_m1  = eff_len - (AW+1)'(1);
    assign at_last = ({1'b0, ptr_q} == len_m1);

    // "issue" means: read mem[ptr] into the output register on this edge, so
    // the entry is presented (ctrl_valid=1) in the following cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        clr_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = step_mode ? HOLD : RUN;
                    ptr_d   = '0;
                    clr_err = 1'b1;
                end
            end
            RUN: begin
                if (stop)           state_d = IDLE;
                else if (step_mode) state_d = HOLD;
                else                issue   = 1'b1;
            end
            HOLD: begin
                if (stop)            state_d = IDLE;
                else if (!step_mode) state_d = RUN;
                else if (step)       issue   = 1'b1;
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = !stop;
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            if (!at_last) begin
                ptr_d = ptr_q + AW'(1);
            end else begin
                ptr_d = '0;
                if (!loop_en) state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ctrl_valid_q <= issue;
            done_q       <= done_d;
        end
    end

    assign ctrl_word  = ram_rdata[MW-1 -: CW_WIDTH];
    assign ctrl_valid = ctrl_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

`ifdef VECTOR_CHECK_EN
    logic [AW-1:0]          ctrl_addr_q, pipe_addr_q, last_err_q;
    logic [RES_WIDTH-1:0]   pipe_exp_q;
    logic                   pipe_valid_q;
    logic [ERR_COUNT_W-1:0] err_q;

    // The pipeline stage follows ctrl_valid regardless of FSM state, so an
    // entry presented in the cycle a stop lands is still compared.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ctrl_addr_q  <= '0;
            pipe_addr_q  <= '0;
            pipe_exp_q   <= '0;
            pipe_valid_q <= 1'b0;
            err_q        <= '0;
            last_err_q   <= '0;
        end else begin
            if (issue) ctrl_addr_q <= ptr_q;
            pipe_valid_q <= ctrl_valid_q;
            pipe_exp_q   <= ram_rdata[RES_WIDTH-1:0];
            pipe_addr_q  <= ctrl_addr_q;
            if (clr_err) begin
                err_q <= '0;
            end else if (pipe_valid_q && observed != pipe_exp_q) begin
                if (err_q != '1) err_q <= err_q + ERR_COUNT_W'(1);
                last_err_q <= pipe_addr_q;
            end
        end
    end

    assign err_count     = err_q;
    assign last_err_addr = last_err_q;
`else
    logic unused_bits;
    assign unused_bits   = ^{observed, wr_data[RES_WIDTH-1:0], clr_err};
    assign err_count     = '0;
    assign last_err_addr = '0;
`endif

endmodule

// File: doc/ctrl_vector_player.md
CTRL_VECTOR_PLAYER -- requirements
Module: ctrl_vector_player

Interface
- REQ-001: Parameter CW_WIDTH, default 42; width of one datapath control word.
- REQ-002: Parameter RES_WIDTH, default 8; width of the observed datapath result.
- REQ-003: Parameter DEPTH, default 16, power of two >= 2; number of vector entries. AW = log2(DEPTH).
- REQ-004: Ports, in this order:
  - Clock  in  1  single clock; all state updates on the rising edge.
  - Reset  in  1  asynchronous, active-low reset.
  - wr_en  in  1  vector-memory write strobe.
  - wr_addr  in  AW  write address.
  - wr_data  in  CW_WIDTH+RES_WIDTH  {control word, expected result}.
  - len  in  AW+1  number of vectors to play, 1..DEPTH.
  - start  in  1  begin playback at entry 0.
  - stop  in  1  abort playback.
  - step_mode  in  1  1 = advance one entry per step pulse.
  - step  in  1  single-step advance pulse.
  - loop_en  in  1  1 = wrap to entry 0 after entry len-1.
  - observed  in  RES_WIDTH  datapath result (ALUOut class) for the previous control word.
  - ctrl_word  out  CW_WIDTH  control word currently driven to the datapath.
  - ctrl_valid  out  1  ctrl_word is a live vector.
  - busy  out  1  FSM is not IDLE.
  - done  out  1  one-cycle pulse when a non-loop run completes.
  - err_count  out  8  number of mismatches, saturating at 255.
  - last_err_addr  out  AW  entry index of the most recent mismatch.

Function
- REQ-005: The FSM SHALL have the states IDLE, RUN, HOLD and DRAIN.
- REQ-006: In IDLE, start=1 SHALL go to RUN, or to HOLD if step_mode=1; it SHALL set the pointer to 0 and clear err_count.
- REQ-007: In RUN, the pointer SHALL advance by 1 every cycle, and ctrl_word SHALL equal mem[pointer].cw registered, with ctrl_valid=1.
- REQ-008: In HOLD, ctrl_valid SHALL be 0 and the pointer SHALL hold; step=1 SHALL present one entry for exactly one cycle, then advance the pointer.
- REQ-009: If loop_en=0, then after entry len-1 is issued the FSM SHALL enter DRAIN for one cycle, then go to IDLE and pulse done=1 for one cycle.
- REQ-010: If loop_en=1, then after entry len-1 the pointer SHALL wrap to 0 with no gap cycle; done SHALL never pulse.
- REQ-011: Check latency SHALL be 1 cycle: observed is compared at the rising edge after the cycle in which the matching ctrl_valid=1. The expected value SHALL travel in a one-stage pipeline with a valid bit. DRAIN exists so that the last entry is checked.
- REQ-012: On a mismatch, err_count SHALL increment (saturating at 255) and last_err_addr SHALL load the index of that entry.
- REQ-013: stop=1 in any state other than IDLE SHALL go to IDLE on the next edge. ctrl_valid SHALL go 0 and done SHALL not pulse. Any pending check SHALL still complete.
- REQ-014: start while busy=1 SHALL be ignored; stop and start asserted together SHALL resolve to stop.
- REQ-015: wr_en SHALL write at any time. A write to the address being read in the same cycle SHALL return the old data (read-before-write).
- REQ-016: len=0 or len>DEPTH SHALL be treated as DEPTH.
- REQ-017: loop_en and step_mode SHALL be sampled every cycle; changing either mid-run SHALL take effect at the next pointer advance.

Reset
- REQ-018: Reset low SHALL immediately force: FSM=IDLE, pointer=0, ctrl_word=0, ctrl_valid=0, busy=0, done=0, err_count=0, last_err_addr=0, check-pipeline valid=0.
- REQ-019: Reset SHALL not clear the vector memory; its contents after reset are don't-care until written.
- REQ-020: Reset asserted mid-run SHALL abandon the run without a done pulse or any further check.

Configuration
- REQ-021: Macro VECTOR_CHECK_EN defined: the expected-result storage, comparator, err_count and last_err_addr logic SHALL be present.
- REQ-022: Macro VECTOR_CHECK_EN undefined: memory width SHALL be CW_WIDTH only, and the low RES_WIDTH bits of wr_data SHALL be ignored. err_count and last_err_addr SHALL be tied to 0. All port widths SHALL remain unchanged.

Structure
- REQ-023: The shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, HOLD=2, DRAIN=3), the default parameter values and the err_count width constant.
- REQ-024: The vector memory SHALL be the sub-module vector_ram: one write port, one synchronous read port, read-before-write.

Verification
- REQ-025: Load 4 entries with expected values 0x05, 0x0A, 0x0F, 0x14; len=4; start; feed observed values that match. Required: ctrl_valid high for 4 cycles, done pulses 2 cycles after the last entry, err_count=0.
- REQ-026: Same run with observed=0xFF on entry 2. Required: err_count=1, last_err_addr=2.
- REQ-027: loop_en=1, len=3, run for 10 cycles. Required: ctrl_word sequence 0,1,2,0,1,2,... with no gap cycles and no done pulse.
- REQ-028: step_mode=1 with step pulses at cycles 3 and 7. Required: ctrl_valid high only at cycles 4 and 8, presenting entries 0 and 1.
- REQ-029: Reset driven low mid-run at entry 2. Required: all outputs equal their reset values before the next edge; memory contents intact on replay.
- REQ-030: stop and start asserted in the same cycle during RUN. Required: IDLE on the next edge, no done pulse; the last issued entry is still checked.
